// File: rtl/aes_decipher_iter.sv
// aes_decipher_iter: iterative AES-256 inverse cipher with on-chip key expansion.
// Optional feature macro: AES_DEC_KEY_CACHE_EN (reuse the expanded key when the next key matches).
module aes_decipher_iter #(
    parameter int KEXP_WPC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [127:0] datain,
    output logic [127:0] dataout,
    output logic         valid,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    if (KEXP_WPC != 1 && KEXP_WPC != 2 && KEXP_WPC != 4) begin : g_bad_wpc
        $error("aes_decipher_iter: KEXP_WPC must be 1, 2 or 4");
    end

    localparam logic [5:0] LAST_WIDX = 6'(60 - KEXP_WPC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_ARK0   = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    // ---------------- GF(2^8) and S-box helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] j);
        logic [7:0] r;
        case (j)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // w[idx] from w[idx-1] (prev) and w[idx-8] (old); idx mod 8 selects the schedule step.
    function automatic logic [31:0] kexp_word(input logic [31:0] prev, input logic [31:0] old,
                                              input logic [5:0] idx);
        logic [31:0] t;
        t = prev;
        if (idx[2:0] == 3'd0)
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon(idx[5:3]), 24'h000000};
        else if (idx[2:0] == 3'd4)
            t = sub_word(t);
        return old ^ t;
    endfunction

    // State byte n sits at [127-8n -: 8]; byte n is row n%4, column n/4.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ---------------- registers and datapath wires ----------------
    state_t       r_state;
    logic [3:0]   r_rnd;
    logic [5:0]   r_widx;
    logic [31:0]  r_w [60];
    logic [127:0] r_st;
    logic [127:0] r_dout;
    logic         r_valid;
    logic         r_busy;

    logic [31:0]  w_kexp [KEXP_WPC];
    logic [31:0]  w_prev;
    logic [127:0] w_rk;
    logic [127:0] w_rk0;
    logic [127:0] w_rk14;
    logic [127:0] w_inv_ss;
    logic [127:0] w_round;
    logic [127:0] w_final;

`ifdef AES_DEC_KEY_CACHE_EN
    logic         r_cache_vld;
    logic         w_key_hit;

    // r_w[0..7] always holds the raw key of the last expansion, so it doubles as the cached key.
    assign w_key_hit = r_cache_vld &&
        (key == {r_w[0], r_w[1], r_w[2], r_w[3], r_w[4], r_w[5], r_w[6], r_w[7]});
`endif

    // Words r_widx .. r_widx+KEXP_WPC-1 are chained combinationally within one cycle.
    always_comb begin
        w_kexp = '{default: '0};
        w_prev = r_w[6'(r_widx - 6'd1)];
        for (int k = 0; k < KEXP_WPC; k++) begin
            w_kexp[k] = kexp_word(w_prev, r_w[6'(r_widx + 6'(k) - 6'd8)], 6'(r_widx + 6'(k)));
            w_prev    = w_kexp[k];
        end
    end

    assign w_rk     = {r_w[{r_rnd, 2'd0}], r_w[{r_rnd, 2'd1}], r_w[{r_rnd, 2'd2}], r_w[{r_rnd, 2'd3}]};
    assign w_rk0    = {r_w[0], r_w[1], r_w[2], r_w[3]};
    assign w_rk14   = {r_w[56], r_w[57], r_w[58], r_w[59]};
    assign w_inv_ss = inv_shift_sub(r_st);
    assign w_round  = inv_mix_columns(w_inv_ss ^ w_rk);
    assign w_final  = w_inv_ss ^ w_rk0;

    // Handshake: start is sampled only while busy=0 (key/datain captured on that edge);
    // busy then stays high until the edge that raises the one-cycle valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rnd   <= 4'd0;
            r_widx  <= 6'd8;
            r_st    <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < 60; i++) r_w[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            r_cache_vld <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_st   <= datain;
                        r_busy <= 1'b1;
                        r_widx <= 6'd8;
                        for (int i = 0; i < 8; i++) r_w[i] <= key[255 - 32*i -: 32];
`ifdef AES_DEC_KEY_CACHE_EN
                        if (w_key_hit) begin
                            r_state <= S_ARK0;
                        end else begin
                            r_cache_vld <= 1'b0;
                            r_state     <= S_KEYEXP;
                        end
`else
                        r_state <= S_KEYEXP;
`endif
                    end
                end
                S_KEYEXP: begin
                    for (int k = 0; k < KEXP_WPC; k++) r_w[6'(r_widx + 6'(k))] <= w_kexp[k];
                    if (r_widx == LAST_WIDX) begin
                        r_widx  <= 6'd8;
                        r_state <= S_ARK0;
`ifdef AES_DEC_KEY_CACHE_EN
                        r_cache_vld <= 1'b1;
`endif
                    end else begin
                        r_widx <= r_widx + 6'(KEXP_WPC);
                    end
                end
                S_ARK0: begin
                    r_st    <= r_st ^ w_rk14;
                    r_rnd   <= 4'd13;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_st  <= w_round;
                    r_rnd <= r_rnd - 4'd1;
                    if (r_rnd == 4'd1) r_state <= S_FINAL;
                end
                S_FINAL: begin
                    r_dout  <= w_final;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dataout   = r_dout;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
